// File: rtl/digclk_pkg.sv
// Shared limits, set-mode encodings and a wrapping step helper for the
// hours/minutes/seconds clock.
package digclk_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_SEC  = 2'b01,
    SET_MIN  = 2'b10,
    SET_HOUR = 2'b11
  } set_sel_e;

  // Steps a field by +/-1, wrapping inside 0..max with no carry out.
  function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                           input logic [5:0] max,
                                           input logic       up);
    if (up) return (v == max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for one
// pushbutton. The button must be seen low after reset before a rise counts.
module pb_sync_edge (
  input  logic clk_100M,
  input  logic reset,
  input  logic pb,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_d_q;
  logic primed_q;
  logic armed_q;

  // primed_q marks that sync1_q holds a real post-reset sample, so a button
  // held across reset release never arms the detector until it is let go.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync2_d_q <= 1'b0;
      primed_q  <= 1'b0;
      armed_q   <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync1_q   <= pb;
      sync2_q   <= sync1_q;
      sync2_d_q <= sync2_q;
      primed_q  <= 1'b1;
      armed_q   <= armed_q | (primed_q & ~sync1_q);
      rise      <= sync2_q & ~sync2_d_q & armed_q;
    end
  end

endmodule

// File: rtl/digclk_hms.sv
// Hours/minutes/seconds clock with a 1 Hz prescaler and pushbutton
// set modes; 24-hour or 12-hour-with-PM display selected by H24.
module digclk_hms
  import digclk_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter bit          H24    = 1'b1
) (
  input  logic       clk_100M,
  input  logic       reset,
  input  logic       incr_pb,
  input  logic       decr_pb,
  input  logic [1:0] set_sel,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [4:0] hour_out,
  output logic       pm_out,
  output logic       tick_1hz
);

  localparam int unsigned   PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  set_sel_e      mode;
  logic          incr_rise;
  logic          decr_rise;
  logic          tick;
  logic          step_en;
  logic [PW-1:0] presc_q;
  logic [5:0]    sec_q, min_q, hour_q;
  logic [5:0]    sec_nx, min_nx, hour_nx;
  logic [5:0]    hour_pm;
  logic [4:0]    hour_disp;
  logic          pm_disp;

  assign mode = set_sel_e'(set_sel);

  pb_sync_edge u_incr (
    .clk_100M (clk_100M),
    .reset    (reset),
    .pb       (incr_pb),
    .rise     (incr_rise)
  );

  pb_sync_edge u_decr (
    .clk_100M (clk_100M),
    .reset    (reset),
    .pb       (decr_pb),
    .rise     (decr_rise)
  );

  assign tick    = (mode == RUN) && (presc_q == PRESC_LAST);
  // Opposing edges in the same cycle cancel out.
  assign step_en = (mode != RUN) && (incr_rise ^ decr_rise);

  always_comb begin
    sec_nx  = sec_q;
    min_nx  = min_q;
    hour_nx = hour_q;
    if (tick) begin
      sec_nx = step_wrap(sec_q, SEC_MAX, 1'b1);
      if (sec_q == SEC_MAX) begin
        min_nx = step_wrap(min_q, MIN_MAX, 1'b1);
        if (min_q == MIN_MAX) hour_nx = step_wrap(hour_q, HOUR_MAX, 1'b1);
      end
    end else if (step_en) begin
      case (mode)
        SET_SEC:  sec_nx  = step_wrap(sec_q, SEC_MAX, incr_rise);
        SET_MIN:  min_nx  = step_wrap(min_q, MIN_MAX, incr_rise);
        SET_HOUR: hour_nx = step_wrap(hour_q, HOUR_MAX, incr_rise);
        default:  ;
      endcase
    end
  end

  // Any set mode holds the prescaler at zero, discarding a partial second.
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 6'd0;
    end else begin
      presc_q <= (mode != RUN || tick) ? '0 : presc_q + PW'(1);
      sec_q   <= sec_nx;
      min_q   <= min_nx;
      hour_q  <= hour_nx;
    end
  end

  always_comb begin
    hour_pm   = hour_q - 6'd12;
    hour_disp = hour_q[4:0];
    pm_disp   = 1'b0;
    if (!H24) begin
      if (hour_q == 6'd0) hour_disp = 5'd12;
      else if (hour_q > 6'd12) hour_disp = hour_pm[4:0];
      pm_disp = (hour_q >= 6'd12);
    end
  end

  assign sec_out  = sec_q;
  assign min_out  = min_q;
  assign hour_out = hour_disp;
  assign pm_out   = pm_disp;
  assign tick_1hz = tick;

endmodule

// File: tb/tb_digclk_hms.sv
// Bench for digclk_hms: one 24-hour and one 12-hour instance share stimulus;
// a time-of-day reference model feeds an expected queue checked every cycle.
module tb_digclk_hms;

  localparam int CLK_HZ = 10;
  localparam int W      = 38;

  logic       clk_100M = 1'b0;
  logic       reset    = 1'b1;
  logic       incr_pb  = 1'b0;
  logic       decr_pb  = 1'b0;
  logic [1:0] set_sel  = 2'b00;

  logic [5:0] a_sec, a_min, b_sec, b_min;
  logic [4:0] a_hour, b_hour;
  logic       a_pm, b_pm, a_tick, b_tick;

  digclk_hms #(.CLK_HZ(CLK_HZ), .H24(1'b1)) dut24 (
    .clk_100M (clk_100M), .reset (reset), .incr_pb (incr_pb), .decr_pb (decr_pb),
    .set_sel  (set_sel),  .sec_out (a_sec), .min_out (a_min), .hour_out (a_hour),
    .pm_out   (a_pm),     .tick_1hz (a_tick)
  );

  digclk_hms #(.CLK_HZ(CLK_HZ), .H24(1'b0)) dut12 (
    .clk_100M (clk_100M), .reset (reset), .incr_pb (incr_pb), .decr_pb (decr_pb),
    .set_sel  (set_sel),  .sec_out (b_sec), .min_out (b_min), .hour_out (b_hour),
    .pm_out   (b_pm),     .tick_1hz (b_tick)
  );

  // clock / reset
  always #5 clk_100M = ~clk_100M;

  int         errors = 0;
  int         checks = 0;
  bit         done   = 1'b0;
  logic [W-1:0] exp_q[$];

  // reference model: wall-clock time plus elapsed cycles in the current second
  int       m_h, m_m, m_s, m_cnt;
  bit       inc_last, dec_last, last_v;
  bit [2:0] inc_pipe, dec_pipe;

  function automatic void model_clear();
    m_h = 0; m_m = 0; m_s = 0; m_cnt = 0;
    inc_last = 1'b0; dec_last = 1'b0; last_v = 1'b0;
    inc_pipe = 3'b000; dec_pipe = 3'b000;
  endfunction

  function automatic void model_edge();
    int  tod;
    int  d;
    bit  pi, pd;
    if (set_sel == 2'b00) begin
      if (m_cnt == CLK_HZ - 1) begin
        tod   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h   = tod / 3600;
        m_m   = (tod / 60) % 60;
        m_s   = tod % 60;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
      d = int'(inc_pipe[2]) - int'(dec_pipe[2]);
      if (d != 0) begin
        case (set_sel)
          2'b01:   m_s = (m_s + d + 60) % 60;
          2'b10:   m_m = (m_m + d + 60) % 60;
          default: m_h = (m_h + d + 24) % 24;
        endcase
      end
    end
    // a press is a low-to-high step between two post-reset samples,
    // taking effect three edges after the high sample
    pi = last_v && incr_pb && !inc_last;
    pd = last_v && decr_pb && !dec_last;
    inc_pipe = {inc_pipe[1:0], pi};
    dec_pipe = {dec_pipe[1:0], pd};
    inc_last = incr_pb;
    dec_last = decr_pb;
    last_v   = 1'b1;
  endfunction

  function automatic logic [W-1:0] model_expect();
    logic       t;
    logic [4:0] h12;
    t   = (set_sel == 2'b00) && (m_cnt == CLK_HZ - 1) && !reset;
    h12 = 5'((m_h % 12 == 0) ? 12 : m_h % 12);
    return {t, 6'(m_s), 6'(m_m), 5'(m_h), 1'b0,
            t, 6'(m_s), 6'(m_m), h12, (m_h >= 12)};
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk_100M);
      if (reset) model_clear();
      else       model_edge();
      #2;
      if (reset) model_clear();
      if (!done) exp_q.push_back(model_expect());
    end
  end

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk_100M);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {a_tick, a_sec, a_min, a_hour, a_pm, b_tick, b_sec, b_min, b_hour, b_pm};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs t=%0t: actual 24h %0d:%0d:%0d tick=%0b | 12h %0d:%0d:%0d pm=%0b tick=%0b ; required vector %h got %h",
                   $time, a_hour, a_min, a_sec, a_tick, b_hour, b_min, b_sec, b_pm, b_tick,
                   exp_v, act_v);
        end
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100M);
      #1;
    end
  endtask

  task automatic press(input bit inc, input bit dec, input int hold, input int gap);
    incr_pb = inc;
    decr_pb = dec;
    cyc(hold);
    incr_pb = 1'b0;
    decr_pb = 1'b0;
    cyc(gap);
  endtask

  task automatic presses(input bit inc, input int n);
    repeat (n) press(inc, !inc, 2, 4);
  endtask

  task automatic check_now(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    int k;
    cyc(3);
    reset = 1'b0;

    // set 23:59:59 by decrementing each field from zero, then roll over
    set_sel = 2'b11; presses(1'b0, 1);
    set_sel = 2'b10; presses(1'b0, 1);
    set_sel = 2'b01; presses(1'b0, 1);
    set_sel = 2'b00; cyc(25);

    // minute 59 -> 0 with a long hold
    set_sel = 2'b10; presses(1'b0, 1);
    press(1'b1, 1'b0, 20, 4);

    // hour 0 -> 23 -> 13 (1 PM)
    set_sel = 2'b11; presses(1'b0, 1);
    presses(1'b1, 14);

    // simultaneous buttons, then buttons in run mode
    set_sel = 2'b01; press(1'b1, 1'b1, 3, 4);
    set_sel = 2'b00; press(1'b1, 1'b0, 3, 4);
    press(1'b0, 1'b1, 3, 4);
    cyc(5);

    // randomized modes and presses
    repeat (40) begin
      set_sel = 2'($urandom_range(0, 3));
      k = int'($urandom_range(0, 3));
      press(k == 1 || k == 3, k == 2 || k == 3,
            int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
      cyc(int'($urandom_range(0, 12)));
    end

    // reach 12:34:56, reset mid-second with a button held across release
    set_sel = 2'b00;
    pulse_reset();
    set_sel = 2'b11; presses(1'b1, 12);
    set_sel = 2'b10; presses(1'b1, 34);
    set_sel = 2'b01; presses(1'b0, 4);
    set_sel = 2'b00; cyc(5);
    check_now("preset_hour", int'(a_hour), 12);
    check_now("preset_min", int'(a_min), 34);
    check_now("preset_sec", int'(a_sec), 56);
    reset   = 1'b1;
    incr_pb = 1'b1;
    #1;
    check_now("async_sec", int'(a_sec), 0);
    check_now("async_min", int'(a_min), 0);
    check_now("async_hour24", int'(a_hour), 0);
    check_now("async_hour12", int'(b_hour), 12);
    check_now("async_pm12", int'(b_pm), 0);
    check_now("async_tick", int'(a_tick), 0);
    cyc(3);
    reset = 1'b0;
    set_sel = 2'b01;
    cyc(6);
    set_sel = 2'b00;
    cyc(25);
    incr_pb = 1'b0;
    cyc(5);

    done = 1'b1;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
